// File: rtl/perceptron_classifier.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_classifier
// Description : Two-input perceptron inference engine. Waits for a trainer to
//               publish final weights (Finish_Flag), then classifies samples
//               one at a time over a valid/ready handshake using a single
//               shared 14x7 signed multiplier (two multiply cycles/sample).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro : ACCURACY_CNT_EN
//   defined   -> Err_Count counts delivered results with Y != expected t
//   undefined -> Err_Count is tied to zero, no comparator is built
// ----------------------------------------------------------------------------
// Ports
//   Clk, Rst          clock, asynchronous active-high reset
//   Finish_Flag       trainer strobe: W1in/W2in/Bin hold final weights
//   W1in, W2in, Bin   signed 14-bit weights and bias
//   x1, x2            signed 7-bit features
//   t                 expected class (01 = +1, 11 = -1)
//   in_valid/in_ready sample handshake
//   out_valid/out_ready result handshake
//   Y                 class (01 = +1, 11 = -1, 00 = dead-band)
//   net               signed 22-bit pre-activation sum
//   Sample_Count      delivered results (saturating)
//   Err_Count         misclassified delivered results (saturating)
// ============================================================================
module perceptron_classifier #(
    parameter int THETA = 0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Finish_Flag,
    input  logic [13:0] W1in,
    input  logic [13:0] W2in,
    input  logic [13:0] Bin,
    input  logic [6:0]  x1,
    input  logic [6:0]  x2,
    input  logic [1:0]  t,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  Y,
    output logic [21:0] net,
    output logic [7:0]  Sample_Count,
    output logic [7:0]  Err_Count
);

    localparam logic signed [21:0] THETA_POS = 22'(THETA);
    localparam logic signed [21:0] THETA_NEG = -THETA_POS;

    typedef enum logic [2:0] {
        WAIT_W = 3'd0,
        IDLE   = 3'd1,
        MUL1   = 3'd2,
        MUL2   = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [13:0]        w1_q, w2_q, b_q;
    logic [6:0]         x1_q, x2_q;
    logic signed [21:0] acc_q;
    logic [21:0]        net_q;
    logic [1:0]         y_q, y_d;
    logic [7:0]         cnt_q;

    logic               accept, deliver, wload;
    logic [13:0]        mul_a;
    logic [6:0]         mul_b;
    logic signed [21:0] prod, addend, acc_sum;

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        deliver   = 1'b0;
        case (state_q)
            WAIT_W: if (Finish_Flag) state_d = IDLE;
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = MUL1;
                end
            end
            MUL1: state_d = MUL2;
            MUL2: state_d = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_W;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= WAIT_W;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Shared multiplier: W1*x1 in MUL1, W2*x2 in MUL2. Operands are
    // sign-extended to the accumulator width so the low 22 bits of the
    // product are the exact signed result (|product| < 2^20).
    // ------------------------------------------------------------------
    assign wload   = Finish_Flag && ((state_q == WAIT_W) || (state_q == IDLE));
    assign mul_a   = (state_q == MUL2) ? w2_q : w1_q;
    assign mul_b   = (state_q == MUL2) ? x2_q : x1_q;
    assign prod    = {{8{mul_a[13]}}, mul_a} * {{15{mul_b[6]}}, mul_b};
    // MUL1 starts from the sign-extended bias, MUL2 continues the sum
    assign addend  = (state_q == MUL2) ? acc_q : {{8{b_q[13]}}, b_q};
    assign acc_sum = addend + prod;

    always_comb begin
        y_d = 2'b00;
        if (acc_sum > THETA_POS)      y_d = 2'b01;
        else if (acc_sum < THETA_NEG) y_d = 2'b11;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            w1_q  <= '0;
            w2_q  <= '0;
            b_q   <= '0;
            x1_q  <= '0;
            x2_q  <= '0;
            acc_q <= '0;
            net_q <= '0;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (wload) begin
                w1_q <= W1in;
                w2_q <= W2in;
                b_q  <= Bin;
            end
            if (accept) begin
                x1_q <= x1;
                x2_q <= x2;
            end
            if (state_q == MUL1) acc_q <= acc_sum;
            if (state_q == MUL2) begin
                acc_q <= acc_sum;
                net_q <= acc_sum;
                y_q   <= y_d;
            end
            if (deliver && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign Y            = y_q;
    assign net          = net_q;
    assign Sample_Count = cnt_q;

`ifdef ACCURACY_CNT_EN
    logic [1:0] t_q;
    logic [7:0] err_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            t_q   <= '0;
            err_q <= '0;
        end else begin
            if (accept) t_q <= t;
            if (deliver && (y_q != t_q) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        end
    end

    assign Err_Count = err_q;
`else
    // Expected class is only needed for error counting
    logic unused_t;
    assign unused_t  = ^t;
    assign Err_Count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_perceptron_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_perceptron_classifier
// Description : Self-checking bench. Two instances share all inputs: one with
//               THETA=0 and one with THETA=2, so every vector also checks the
//               dead-band threshold. Vector table plus hand-written sequences
//               for back-pressure, weight freezing and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_classifier;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Finish_Flag = 1'b0;
    logic [13:0] W1in = '0, W2in = '0, Bin = '0;
    logic [6:0]  x1 = '0, x2 = '0;
    logic [1:0]  t = 2'b01;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, in_ready2, out_valid2;
    logic [1:0]  Y0, Y2;
    logic [21:0] net0, net2;
    logic [7:0]  sc0, ec0, sc2, ec2;

    always #5 Clk = ~Clk;

    perceptron_classifier #(.THETA(0)) dut (
        .Clk(Clk), .Rst(Rst), .Finish_Flag(Finish_Flag),
        .W1in(W1in), .W2in(W2in), .Bin(Bin), .x1(x1), .x2(x2), .t(t),
        .in_valid(in_valid), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .Y(Y0), .net(net0), .Sample_Count(sc0), .Err_Count(ec0)
    );

    perceptron_classifier #(.THETA(2)) dut_t2 (
        .Clk(Clk), .Rst(Rst), .Finish_Flag(Finish_Flag),
        .W1in(W1in), .W2in(W2in), .Bin(Bin), .x1(x1), .x2(x2), .t(t),
        .in_valid(in_valid), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .Y(Y2), .net(net2), .Sample_Count(sc2), .Err_Count(ec2)
    );

    typedef struct {
        logic [13:0] w1, w2, b;
        logic [6:0]  x1, x2;
        logic [1:0]  t;
        logic [21:0] net;
        logic [1:0]  y0, y2;
    } vec_t;

    vec_t vecs[7];

    int n_vec = 0;
    int n_bad = 0;
    int exp_sc = 0;
    int exp_err0 = 0;
    int exp_err2 = 0;

    task automatic chk(input string nm, input logic [21:0] act, input logic [21:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_vec(input int i, input int w1, input int w2, input int b,
                           input int a1, input int a2, input logic [1:0] tt,
                           input int nt, input logic [1:0] ya, input logic [1:0] yb);
        vecs[i].w1  = 14'(w1);
        vecs[i].w2  = 14'(w2);
        vecs[i].b   = 14'(b);
        vecs[i].x1  = 7'(a1);
        vecs[i].x2  = 7'(a2);
        vecs[i].t   = tt;
        vecs[i].net = 22'(nt);
        vecs[i].y0  = ya;
        vecs[i].y2  = yb;
    endtask

    task automatic load_w(input logic [13:0] a, input logic [13:0] b2, input logic [13:0] c);
        W1in = a; W2in = b2; Bin = c;
        Finish_Flag = 1'b1;
        tick();
        Finish_Flag = 1'b0;
    endtask

    task automatic check_counts(input string nm);
        chk({nm, "_sc"}, 22'(sc0), 22'(exp_sc));
`ifdef ACCURACY_CNT_EN
        chk({nm, "_err0"}, 22'(ec0), 22'(exp_err0));
        chk({nm, "_err2"}, 22'(ec2), 22'(exp_err2));
`else
        chk({nm, "_err0"}, 22'(ec0), 22'd0);
        chk({nm, "_err2"}, 22'(ec2), 22'd0);
`endif
    endtask

    // Accept a sample, check latency, result and delivery
    task automatic run_vec(input vec_t v, input string nm);
        x1 = v.x1; x2 = v.x2; t = v.t;
        in_valid = 1'b1;
        tick();                                  // accepting edge -> MUL1
        in_valid = 1'b0;
        chk({nm, "_ov_e1"}, 22'(out_valid0), 22'd0);
        chk({nm, "_ir_e1"}, 22'(in_ready0), 22'd0);
        tick();                                  // MUL1 -> MUL2
        chk({nm, "_ov_e2"}, 22'(out_valid0), 22'd0);
        tick();                                  // MUL2 -> OUT
        chk({nm, "_ov_e3"}, 22'(out_valid0), 22'd1);
        chk({nm, "_ir_out"}, 22'(in_ready0), 22'd0);
        chk({nm, "_net"}, net0, v.net);
        chk({nm, "_y0"}, 22'(Y0), 22'(v.y0));
        chk({nm, "_y2"}, 22'(Y2), 22'(v.y2));
        out_ready = 1'b1;
        tick();                                  // delivery edge -> IDLE
        out_ready = 1'b0;
        exp_sc++;
        if (v.y0 != v.t) exp_err0++;
        if (v.y2 != v.t) exp_err2++;
        chk({nm, "_ov_done"}, 22'(out_valid0), 22'd0);
        chk({nm, "_ir_done"}, 22'(in_ready0), 22'd1);
        check_counts(nm);
    endtask

    initial begin
        // w1 w2 b x1 x2 t net Y(THETA=0) Y(THETA=2)
        set_vec(0, 2, 2, -2, 1, 1, 2'b01, 2, 2'b01, 2'b00);
        set_vec(1, 2, 2, -2, 1, -1, 2'b01, -2, 2'b11, 2'b00);
        set_vec(2, -8192, -8192, -8192, -64, -64, 2'b01, 1040384, 2'b01, 2'b01);
        set_vec(3, 5, -3, 10, -10, 20, 2'b11, -100, 2'b11, 2'b11);
        set_vec(4, 8191, 8191, 8191, 63, 63, 2'b01, 1040257, 2'b01, 2'b01);
        set_vec(5, 1, 0, -3, 0, 5, 2'b11, -3, 2'b11, 2'b11);
        set_vec(6, 0, 0, 0, 17, -33, 2'b11, 0, 2'b00, 2'b00);

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_ov", 22'(out_valid0), 22'd0);
        chk("rst_ir", 22'(in_ready0), 22'd0);
        chk("rst_net", net0, 22'd0);
        chk("rst_y", 22'(Y0), 22'd0);
        check_counts("rst");
        Rst = 1'b0;
        tick();
        tick();
        chk("waitw_ir", 22'(in_ready0), 22'd0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 7; i++) begin
            load_w(vecs[i].w1, vecs[i].w2, vecs[i].b);
            chk($sformatf("v%0d_ir_load", i), 22'(in_ready0), 22'd1);
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // ---------------- back-pressure + weight freeze ----------------
        load_w(14'd2, 14'd2, -14'sd2);
        x1 = 7'd1; x2 = 7'd1; t = 2'b01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Different weights offered while computing must be ignored
        W1in = 14'd100; W2in = 14'd100; Bin = 14'd100;
        Finish_Flag = 1'b1;
        tick();
        tick();
        Finish_Flag = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_ov", c), 22'(out_valid0), 22'd1);
            chk($sformatf("stall%0d_ir", c), 22'(in_ready0), 22'd0);
            chk($sformatf("stall%0d_net", c), net0, 22'd2);
            chk($sformatf("stall%0d_y", c), 22'(Y0), 22'b01);
            chk($sformatf("stall%0d_sc", c), 22'(sc0), 22'(exp_sc));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_sc++;
        exp_err2++;                               // THETA=2 gives 00 vs t=01
        chk("stall_rel_ov", 22'(out_valid0), 22'd0);
        tick();
        tick();
        check_counts("stall_rel");

        // ---------------- reset in MUL2 ----------------
        load_w(14'd2, 14'd2, -14'sd2);
        x1 = 7'd1; x2 = 7'd1; t = 2'b01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();                                   // now in MUL2
        #2 Rst = 1'b1;
        #1;
        exp_sc = 0; exp_err0 = 0; exp_err2 = 0;
        chk("midrst_ov", 22'(out_valid0), 22'd0);
        chk("midrst_ir", 22'(in_ready0), 22'd0);
        chk("midrst_net", net0, 22'd0);
        check_counts("midrst");
        tick();
        Rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("postrst%0d_ov", c), 22'(out_valid0), 22'd0);
            chk($sformatf("postrst%0d_ir", c), 22'(in_ready0), 22'd0);
        end
        check_counts("postrst");
        load_w(vecs[1].w1, vecs[1].w2, vecs[1].b);
        chk("postrst_ir_load", 22'(in_ready0), 22'd1);
        run_vec(vecs[1], "postrst_v1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
